// File: rtl/int_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : int_sched_pkg
// Purpose  : Shared definitions for the interrupt scheduler: source count,
//            FSM state encoding, default handler-table layout (also used by
//            the PC interrupt mux and the program-memory map) and the
//            vector-address helper.
// Revision : 1.0 - initial release
// ============================================================================
package int_sched_pkg;

  localparam int N_SRC = 4;

  localparam logic [9:0] VEC_BASE_DEFAULT   = 10'h3C0;
  localparam logic [9:0] VEC_STRIDE_DEFAULT = 10'h010;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  // Handler address of a source; wraps modulo 2^10 like the PC.
  function automatic logic [9:0] vec_addr(input logic [9:0] base,
                                          input logic [9:0] stride,
                                          input logic [1:0] idx);
    return base + ({8'd0, idx} * stride);
  endfunction

endpackage
`default_nettype wire

// File: rtl/int_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : int_sched_if
// Purpose  : Bundle of interrupt lines, mask write port and the UC
//            request/acknowledge/end handshake.
//   slave  : scheduler side (takes irq/mask/ack/end, drives req/vector/status)
//   master : control-unit / source side
// Revision : 1.0 - initial release
// ============================================================================
interface int_sched_if;
  logic [3:0] irq_in;
  logic       mask_we;
  logic [3:0] mask_in;
  logic       int_ack;
  logic       int_end;
  logic       int_req;
  logic [9:0] vector;
  logic [3:0] in_service;
  logic [3:0] pending;
  logic [3:0] mask;

  modport slave (
    input  irq_in, mask_we, mask_in, int_ack, int_end,
    output int_req, vector, in_service, pending, mask
  );

  modport master (
    output irq_in, mask_we, mask_in, int_ack, int_end,
    input  int_req, vector, in_service, pending, mask
  );
endinterface
`default_nettype wire

// File: rtl/int_sched_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : int_sched_rr_pick
// Purpose  : Combinational arbiter. Returns the first eligible source at or
//            after the pointer, searching cyclically. With the pointer tied
//            to 0 it is a plain fixed-priority (lowest index) picker.
// Ports    : eligible[4] in, pointer[2] in, grant[4] one-hot out,
//            index[2] out (0 when nothing is eligible)
// Revision : 1.0 - initial release
// ============================================================================
module int_sched_rr_pick
  import int_sched_pkg::*;
(
  input  logic [N_SRC-1:0] eligible,
  input  logic [1:0]       pointer,
  output logic [N_SRC-1:0] grant,
  output logic [1:0]       index
);

  logic [1:0] cand;
  logic       found;

  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < N_SRC; i++) begin
      cand = pointer + 2'(i);  // 2-bit add wraps around the source ring
      if (!found && eligible[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        index       = cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/int_sched.sv
`default_nettype none
// ============================================================================
// Module   : int_sched
// Purpose  : Interrupt scheduler for the single-cycle CPU. Edge-detects four
//            level interrupt lines into a pending register, masks them,
//            picks a winner (fixed or round-robin) and runs the UC
//            request/ack/end handshake, supplying the handler vector.
// Ports    : clk   - system clock, rising edge
//            reset - asynchronous active-low reset
//            bus   - int_sched_if.slave (irq_in, mask_we, mask_in, int_ack,
//                    int_end in; int_req, vector, in_service, pending, mask out)
// Revision : 1.0 - initial release
// ============================================================================
module int_sched
  import int_sched_pkg::*;
#(
  parameter int         NSRC       = N_SRC,
  parameter logic [9:0] VEC_BASE   = VEC_BASE_DEFAULT,
  parameter logic [9:0] VEC_STRIDE = VEC_STRIDE_DEFAULT,
  parameter bit         RR         = 1'b1,
  parameter logic [3:0] MASK_RST   = 4'b1111
) (
  input  logic        clk,
  input  logic        reset,
  int_sched_if.slave  bus
);

  state_t            state_q, state_d;
  logic [NSRC-1:0]   irq_prev_q;
  logic [NSRC-1:0]   pending_q, pending_d;
  logic [NSRC-1:0]   mask_q, mask_d;
  logic [NSRC-1:0]   grant_q, grant_d;
  logic [NSRC-1:0]   in_service_q, in_service_d;
  logic [1:0]        idx_q, idx_d;
  logic [1:0]        ptr_q, ptr_d;
  logic              int_req_q, int_req_d;
  logic [9:0]        vector_q, vector_d;

  logic [NSRC-1:0]   w_rise;
  logic [NSRC-1:0]   w_eligible;
  logic [NSRC-1:0]   w_pick_grant;
  logic [1:0]        w_pick_idx;
  logic [1:0]        w_pointer;

  assign w_rise     = bus.irq_in & ~irq_prev_q;
  // Registered mask: a write in the same cycle only affects the next decision.
  assign w_eligible = pending_q & mask_q;
  assign w_pointer  = RR ? ptr_q : 2'd0;

  int_sched_rr_pick u_pick (
    .eligible (w_eligible),
    .pointer  (w_pointer),
    .grant    (w_pick_grant),
    .index    (w_pick_idx)
  );

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q | w_rise;
    mask_d       = bus.mask_we ? bus.mask_in : mask_q;
    grant_d      = grant_q;
    in_service_d = in_service_q;
    idx_d        = idx_q;
    ptr_d        = ptr_q;
    int_req_d    = int_req_q;
    vector_d     = vector_q;

    case (state_q)
      S_IDLE: begin
        if (|w_eligible) begin
          grant_d   = w_pick_grant;
          idx_d     = w_pick_idx;
          vector_d  = vec_addr(VEC_BASE, VEC_STRIDE, w_pick_idx);
          int_req_d = 1'b1;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        // int_end is deliberately ignored here, even alongside int_ack.
        if (bus.int_ack) begin
          // A fresh rise on the granted line in this cycle must survive.
          pending_d    = (pending_q & ~grant_q) | w_rise;
          in_service_d = grant_q;
          int_req_d    = 1'b0;
          state_d      = S_SERVICE;
        end
      end
      S_SERVICE: begin
        if (bus.int_end) begin
          in_service_d = '0;
          grant_d      = '0;
          if (RR) ptr_d = idx_q + 2'd1;
          state_d      = S_IDLE;
        end
      end
      default: begin
        state_d   = S_IDLE;
        int_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      irq_prev_q   <= '0;
      pending_q    <= '0;
      mask_q       <= MASK_RST;
      grant_q      <= '0;
      in_service_q <= '0;
      idx_q        <= '0;
      ptr_q        <= '0;
      int_req_q    <= 1'b0;
      vector_q     <= VEC_BASE;
    end else begin
      state_q      <= state_d;
      irq_prev_q   <= bus.irq_in;
      pending_q    <= pending_d;
      mask_q       <= mask_d;
      grant_q      <= grant_d;
      in_service_q <= in_service_d;
      idx_q        <= idx_d;
      ptr_q        <= ptr_d;
      int_req_q    <= int_req_d;
      vector_q     <= vector_d;
    end
  end

  assign bus.int_req    = int_req_q;
  assign bus.vector     = vector_q;
  assign bus.in_service = in_service_q;
  assign bus.pending    = pending_q;
  assign bus.mask       = mask_q;

endmodule
`default_nettype wire

// File: tb/tb_int_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_int_sched
// Purpose  : Directed self-checking bench for int_sched. One instance runs
//            round-robin priority, a second runs fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
module tb_int_sched;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  int_sched_if bus_rr ();
  int_sched_if bus_fx ();

  int_sched #(.RR(1'b1)) u_rr (.clk(clk), .reset(reset), .bus(bus_rr));
  int_sched #(.RR(1'b0)) u_fx (.clk(clk), .reset(reset), .bus(bus_fx));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ack_rr();
    bus_rr.int_ack = 1'b1; tick(); bus_rr.int_ack = 1'b0;
  endtask
  task automatic end_rr();
    bus_rr.int_end = 1'b1; tick(); bus_rr.int_end = 1'b0;
  endtask
  task automatic ack_fx();
    bus_fx.int_ack = 1'b1; tick(); bus_fx.int_ack = 1'b0;
  endtask
  task automatic end_fx();
    bus_fx.int_end = 1'b1; tick(); bus_fx.int_end = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    checks++; if (bus_rr.int_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", bus_rr.int_req); end
    checks++; if (bus_rr.vector !== 10'h3C0) begin errors++; $display("FAIL rst_vector: got %h want 3c0", bus_rr.vector); end
    checks++; if (bus_rr.mask !== 4'b1111) begin errors++; $display("FAIL rst_mask: got %b want 1111", bus_rr.mask); end
    checks++; if (bus_rr.pending !== 4'b0000) begin errors++; $display("FAIL rst_pending: got %b want 0000", bus_rr.pending); end
    checks++; if (bus_rr.in_service !== 4'b0000) begin errors++; $display("FAIL rst_in_service: got %b want 0000", bus_rr.in_service); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    bus_rr.irq_in = 4'b0100;
    tick();
    checks++; if (bus_rr.pending !== 4'b0100) begin errors++; $display("FAIL basic_pending: got %b want 0100", bus_rr.pending); end
    checks++; if (bus_rr.int_req !== 1'b0) begin errors++; $display("FAIL basic_req_early: got %b want 0", bus_rr.int_req); end
    bus_rr.irq_in = 4'b0000;
    tick();
    checks++; if (bus_rr.int_req !== 1'b1) begin errors++; $display("FAIL basic_req: got %b want 1", bus_rr.int_req); end
    checks++; if (bus_rr.vector !== 10'h3E0) begin errors++; $display("FAIL basic_vector: got %h want 3e0", bus_rr.vector); end
    ack_rr();
    checks++; if (bus_rr.in_service !== 4'b0100) begin errors++; $display("FAIL basic_in_service: got %b want 0100", bus_rr.in_service); end
    checks++; if (bus_rr.pending !== 4'b0000) begin errors++; $display("FAIL basic_pending_clr: got %b want 0000", bus_rr.pending); end
    checks++; if (bus_rr.int_req !== 1'b0) begin errors++; $display("FAIL basic_req_drop: got %b want 0", bus_rr.int_req); end
    end_rr();
    checks++; if (bus_rr.in_service !== 4'b0000) begin errors++; $display("FAIL basic_end: got %b want 0000", bus_rr.in_service); end
    tick();
    checks++; if (bus_rr.int_req !== 1'b0) begin errors++; $display("FAIL basic_idle_req: got %b want 0", bus_rr.int_req); end
  endtask

  task automatic test_mask();
    bus_rr.mask_we = 1'b1; bus_rr.mask_in = 4'b1011;
    tick();
    bus_rr.mask_we = 1'b0;
    checks++; if (bus_rr.mask !== 4'b1011) begin errors++; $display("FAIL mask_write: got %b want 1011", bus_rr.mask); end
    bus_rr.irq_in = 4'b0100;
    tick();
    bus_rr.irq_in = 4'b0000;
    checks++; if (bus_rr.pending !== 4'b0100) begin errors++; $display("FAIL mask_pending: got %b want 0100", bus_rr.pending); end
    tick(); tick();
    checks++; if (bus_rr.int_req !== 1'b0) begin errors++; $display("FAIL mask_blocked: got %b want 0", bus_rr.int_req); end
    bus_rr.mask_we = 1'b1; bus_rr.mask_in = 4'b1111;
    tick();
    bus_rr.mask_we = 1'b0;
    checks++; if (bus_rr.int_req !== 1'b0) begin errors++; $display("FAIL mask_old_used: got %b want 0", bus_rr.int_req); end
    tick();
    checks++; if (bus_rr.int_req !== 1'b1) begin errors++; $display("FAIL mask_unblock_req: got %b want 1", bus_rr.int_req); end
    checks++; if (bus_rr.vector !== 10'h3E0) begin errors++; $display("FAIL mask_unblock_vec: got %h want 3e0", bus_rr.vector); end
    ack_rr();
    end_rr();
  endtask

  task automatic test_round_robin();
    reset = 1'b0; tick(); reset = 1'b1; tick();  // pointer back to source 0
    bus_rr.irq_in = 4'b1001;
    tick();
    bus_rr.irq_in = 4'b0000;
    tick();
    checks++; if (bus_rr.int_req !== 1'b1 || bus_rr.vector !== 10'h3C0) begin errors++; $display("FAIL rr_first: got req=%b vec=%h want req=1 vec=3c0", bus_rr.int_req, bus_rr.vector); end
    ack_rr();
    bus_rr.irq_in = 4'b1001;  // both rise again during service of source 0
    tick();
    bus_rr.irq_in = 4'b0000;
    checks++; if (bus_rr.pending !== 4'b1001 || bus_rr.int_req !== 1'b0) begin errors++; $display("FAIL rr_accum: got pend=%b req=%b want pend=1001 req=0", bus_rr.pending, bus_rr.int_req); end
    end_rr();
    tick();
    checks++; if (bus_rr.int_req !== 1'b1 || bus_rr.vector !== 10'h3F0) begin errors++; $display("FAIL rr_second: got req=%b vec=%h want req=1 vec=3f0", bus_rr.int_req, bus_rr.vector); end
    ack_rr();
    end_rr();
    tick();
    checks++; if (bus_rr.int_req !== 1'b1 || bus_rr.vector !== 10'h3C0) begin errors++; $display("FAIL rr_third: got req=%b vec=%h want req=1 vec=3c0", bus_rr.int_req, bus_rr.vector); end
    ack_rr();
    end_rr();
    tick();
    checks++; if (bus_rr.int_req !== 1'b0 || bus_rr.pending !== 4'b0000) begin errors++; $display("FAIL rr_drained: got req=%b pend=%b want req=0 pend=0000", bus_rr.int_req, bus_rr.pending); end
  endtask

  task automatic test_fixed();
    bus_fx.irq_in = 4'b0110;
    tick();
    bus_fx.irq_in = 4'b0000;
    tick();
    checks++; if (bus_fx.int_req !== 1'b1 || bus_fx.vector !== 10'h3D0) begin errors++; $display("FAIL fx_first: got req=%b vec=%h want req=1 vec=3d0", bus_fx.int_req, bus_fx.vector); end
    ack_fx();
    bus_fx.irq_in = 4'b0010;  // source 1 again while it is in service
    tick();
    bus_fx.irq_in = 4'b0000;
    end_fx();
    tick();
    checks++; if (bus_fx.int_req !== 1'b1 || bus_fx.vector !== 10'h3D0) begin errors++; $display("FAIL fx_second: got req=%b vec=%h want req=1 vec=3d0", bus_fx.int_req, bus_fx.vector); end
    ack_fx();
    end_fx();
    tick();
    checks++; if (bus_fx.int_req !== 1'b1 || bus_fx.vector !== 10'h3E0) begin errors++; $display("FAIL fx_third: got req=%b vec=%h want req=1 vec=3e0", bus_fx.int_req, bus_fx.vector); end
    ack_fx();
    end_fx();
    tick();
    checks++; if (bus_fx.int_req !== 1'b0) begin errors++; $display("FAIL fx_drained: got %b want 0", bus_fx.int_req); end
  endtask

  task automatic test_reraise();
    bus_rr.irq_in = 4'b0010;  // held high throughout
    tick(); tick();
    checks++; if (bus_rr.int_req !== 1'b1 || bus_rr.vector !== 10'h3D0) begin errors++; $display("FAIL rer_req: got req=%b vec=%h want req=1 vec=3d0", bus_rr.int_req, bus_rr.vector); end
    ack_rr();
    checks++; if (bus_rr.pending !== 4'b0000) begin errors++; $display("FAIL rer_held: got %b want 0000", bus_rr.pending); end
    bus_rr.irq_in = 4'b0000;
    tick();
    bus_rr.irq_in = 4'b0010;
    tick();
    checks++; if (bus_rr.pending !== 4'b0010 || bus_rr.int_req !== 1'b0) begin errors++; $display("FAIL rer_svc: got pend=%b req=%b want pend=0010 req=0", bus_rr.pending, bus_rr.int_req); end
    tick();
    checks++; if (bus_rr.int_req !== 1'b0) begin errors++; $display("FAIL rer_no_nest: got %b want 0", bus_rr.int_req); end
    end_rr();
    checks++; if (bus_rr.int_req !== 1'b0) begin errors++; $display("FAIL rer_gap: got %b want 0", bus_rr.int_req); end
    tick();
    checks++; if (bus_rr.int_req !== 1'b1 || bus_rr.vector !== 10'h3D0) begin errors++; $display("FAIL rer_again: got req=%b vec=%h want req=1 vec=3d0", bus_rr.int_req, bus_rr.vector); end
    ack_rr();
    end_rr();
    tick(); tick();
    checks++; if (bus_rr.int_req !== 1'b0 || bus_rr.pending !== 4'b0000) begin errors++; $display("FAIL rer_single: got req=%b pend=%b want req=0 pend=0000", bus_rr.int_req, bus_rr.pending); end
    bus_rr.irq_in = 4'b0000;
    tick();
  endtask

  task automatic test_simultaneous();
    bus_rr.irq_in = 4'b0010;
    tick();
    bus_rr.irq_in = 4'b0000;
    tick();
    checks++; if (bus_rr.int_req !== 1'b1 || bus_rr.vector !== 10'h3D0) begin errors++; $display("FAIL sim_req: got req=%b vec=%h want req=1 vec=3d0", bus_rr.int_req, bus_rr.vector); end
    bus_rr.int_ack = 1'b1; bus_rr.int_end = 1'b1; bus_rr.irq_in = 4'b0010;
    tick();
    bus_rr.int_ack = 1'b0; bus_rr.int_end = 1'b0; bus_rr.irq_in = 4'b0000;
    checks++; if (bus_rr.in_service !== 4'b0010) begin errors++; $display("FAIL sim_ack_end: got %b want 0010", bus_rr.in_service); end
    checks++; if (bus_rr.pending !== 4'b0010) begin errors++; $display("FAIL sim_rise_kept: got %b want 0010", bus_rr.pending); end
    tick();
    checks++; if (bus_rr.in_service !== 4'b0010) begin errors++; $display("FAIL sim_still_svc: got %b want 0010", bus_rr.in_service); end
    end_rr();
    tick();
    checks++; if (bus_rr.int_req !== 1'b1 || bus_rr.vector !== 10'h3D0) begin errors++; $display("FAIL sim_rerequest: got req=%b vec=%h want req=1 vec=3d0", bus_rr.int_req, bus_rr.vector); end
    ack_rr();
    end_rr();
    ack_rr();  // stray ack while idle
    checks++; if (bus_rr.in_service !== 4'b0000 || bus_rr.int_req !== 1'b0) begin errors++; $display("FAIL sim_stray_ack: got svc=%b req=%b want svc=0000 req=0", bus_rr.in_service, bus_rr.int_req); end
  endtask

  task automatic test_reset_mid();
    bus_rr.mask_we = 1'b1; bus_rr.mask_in = 4'b0111;
    tick();
    bus_rr.mask_we = 1'b0;
    bus_rr.irq_in = 4'b0100;
    tick();
    tick();
    checks++; if (bus_rr.int_req !== 1'b1) begin errors++; $display("FAIL rmid_req: got %b want 1", bus_rr.int_req); end
    #2 reset = 1'b0;
    #1;
    checks++; if (bus_rr.int_req !== 1'b0 || bus_rr.pending !== 4'b0000) begin errors++; $display("FAIL rmid_clear: got req=%b pend=%b want req=0 pend=0000", bus_rr.int_req, bus_rr.pending); end
    checks++; if (bus_rr.mask !== 4'b1111 || bus_rr.vector !== 10'h3C0) begin errors++; $display("FAIL rmid_mask_vec: got mask=%b vec=%h want mask=1111 vec=3c0", bus_rr.mask, bus_rr.vector); end
    bus_rr.irq_in = 4'b0000;
    tick();
    reset = 1'b1;
    tick(); tick(); tick();
    checks++; if (bus_rr.int_req !== 1'b0 || bus_rr.pending !== 4'b0000) begin errors++; $display("FAIL rmid_after: got req=%b pend=%b want req=0 pend=0000", bus_rr.int_req, bus_rr.pending); end
  endtask

  initial begin
    bus_rr.irq_in = '0; bus_rr.mask_we = 1'b0; bus_rr.mask_in = '0;
    bus_rr.int_ack = 1'b0; bus_rr.int_end = 1'b0;
    bus_fx.irq_in = '0; bus_fx.mask_we = 1'b0; bus_fx.mask_in = '0;
    bus_fx.int_ack = 1'b0; bus_fx.int_end = 1'b0;
    test_reset();
    test_basic();
    test_mask();
    test_round_robin();
    test_fixed();
    test_reraise();
    test_simultaneous();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
